// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU.
//   - 4-bit operation codes (ADD..MUL); codes 11-15 are illegal.
//   - FSM state encoding: IDLE (ready for work), MUL (iterating multiply),
//     HOLD (result presented, waiting for the consumer).
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SRA  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier (low WIDTH bits of a*b).
// Ports:
//   clk, rst_n    clock / synchronous active-low reset
//   start         latch a/b, clear accumulator and counter, begin iterating
//   a, b          operands (sampled on start)
//   done          combinational: high during the final iteration cycle
//   product       accumulator value including the current iteration's add;
//                 valid to capture when done is high
// Operands are latched on the start edge; the WIDTH iterations then occur on
// the following WIDTH edges. done is asserted in the cycle before the last
// iteration edge so the parent can capture product on that same edge.
module alu_mul_iter
    #(
        parameter int WIDTH = 32
    )
    (
        input  logic             clk,
        input  logic             rst_n,
        input  logic             start,
        input  logic [WIDTH-1:0] a,
        input  logic [WIDTH-1:0] b,
        output logic             done,
        output logic [WIDTH-1:0] product
    );

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] ma_reg, ma_next;
    logic [WIDTH-1:0] mb_reg, mb_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             running_reg, running_next;
    logic [WIDTH-1:0] acc_sum;
    logic             last_iter;

    assign acc_sum   = mb_reg[0] ? (acc_reg + ma_reg) : acc_reg;
    assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
    assign done      = running_reg & last_iter;
    assign product   = acc_sum;

    always_comb begin
        ma_next      = ma_reg;
        mb_next      = mb_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        running_next = running_reg;
        if (start) begin
            ma_next      = a;
            mb_next      = b;
            acc_next     = '0;
            cnt_next     = '0;
            running_next = 1'b1;
        end else if (running_reg) begin
            acc_next = acc_sum;
            ma_next  = ma_reg << 1;
            mb_next  = mb_reg >> 1;
            cnt_next = cnt_reg + CNT_W'(1);
            if (last_iter) begin
                running_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ma_reg      <= '0;
            mb_reg      <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            running_reg <= 1'b0;
        end else begin
            ma_reg      <= ma_next;
            mb_reg      <= mb_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            running_reg <= running_next;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result, zero and signed-overflow flags.
// Ports:
//   clk, rst_n           clock / synchronous active-low reset
//   in_valid, in_ready   input handshake (accept = in_valid & in_ready)
//   op, a, b             operation code and operands; shift amount is
//                        b[SHW-1:0]
//   out_valid, out_ready output handshake; result/zero/ovf stable while
//                        out_valid is high and out_ready is low
//   result, zero, ovf    registered result and flags
//   busy                 multiply iteration in progress
// Single-cycle ops produce out_valid one cycle after accept. MUL takes
// WIDTH+1 cycles. in_ready depends combinationally on out_ready in HOLD so
// that a new op can be accepted in the same cycle the result is consumed.
module alu_pipe
    import alu_pkg::*;
    #(
        parameter int WIDTH  = 32,
        parameter bit MUL_EN = 1'b1
    )
    (
        input  logic             clk,
        input  logic             rst_n,
        input  logic             in_valid,
        output logic             in_ready,
        input  logic [3:0]       op,
        input  logic [WIDTH-1:0] a,
        input  logic [WIDTH-1:0] b,
        output logic             out_valid,
        input  logic             out_ready,
        output logic [WIDTH-1:0] result,
        output logic             zero,
        output logic             ovf,
        output logic             busy
    );

    localparam int SHW = $clog2(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg, zero_next;
    logic             ovf_reg, ovf_next;

    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign in_ready  = (state_reg == IDLE) | ((state_reg == HOLD) & out_ready);
    assign accept    = in_valid & in_ready;
    assign is_mul    = MUL_EN && (op == OP_MUL);
    assign out_valid = (state_reg == HOLD);
    assign busy      = (state_reg == MUL);
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign ovf       = ovf_reg;

    assign sh   = b[SHW-1:0];
    assign sum  = a + b;
    assign diff = a - b;

    // Single-cycle op mux. MUL (handled by the iterator) and illegal codes
    // fall to the default of zero with no overflow.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL:  alu_res = a << sh;
            OP_SRA:  alu_res = $signed(a) >>> sh;
            OP_SRL:  alu_res = a >> sh;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: alu_res = WIDTH'(a < b);
            default: alu_res = '0;
        endcase
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(
                .WIDTH (WIDTH)
            ) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .a       (a),
                .b       (b),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        ovf_next    = ovf_reg;
        mul_start   = 1'b0;
        case (state_reg)
            IDLE, HOLD: begin
                if (accept) begin
                    if (is_mul) begin
                        mul_start  = 1'b1;
                        state_next = MUL;
                    end else begin
                        result_next = alu_res;
                        zero_next   = (alu_res == '0);
                        ovf_next    = alu_ovf;
                        state_next  = HOLD;
                    end
                end else if (state_reg == HOLD && out_ready) begin
                    state_next = IDLE;
                end
            end
            MUL: begin
                // The final iteration's sum is captured on the same edge it
                // is formed, giving WIDTH+1 cycles from accept to out_valid.
                if (mul_done) begin
                    result_next = mul_product;
                    zero_next   = (mul_product == '0);
                    ovf_next    = 1'b0;
                    state_next  = HOLD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            ovf_reg    <= ovf_next;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             busy;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_pipe #(
        .WIDTH  (WIDTH),
        .MUL_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present one op with out_ready=1, step past the accept edge, then
    // sample 1 time unit later (one-cycle latency point).
    task automatic do_op(input logic [3:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        op        = o;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Drain any held result so the block returns to IDLE.
    task automatic settle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'd0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0 || ovf !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset: out_valid=%b result=%h zero=%b ovf=%b busy=%b in_ready=%b, want 0 00000000 0 0 0 1",
                     out_valid, result, zero, ovf, busy, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] reset checked");
    endtask

    task automatic test_add_sub();
        do_op(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'h8000_0000 || ovf !== 1'b1 || zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_ovf: out_valid=%b result=%h ovf=%b zero=%b, want 1 80000000 1 0",
                     out_valid, result, ovf, zero);
        end
        $display("[TB] ADD 7fffffff+1 -> %h ovf=%b", result, ovf);

        do_op(OP_SUB, 32'd5, 32'd5);
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_zero: out_valid=%b result=%h zero=%b ovf=%b, want 1 00000000 1 0",
                     out_valid, result, zero, ovf);
        end
        $display("[TB] SUB 5-5 -> %h zero=%b", result, zero);

        do_op(OP_SUB, 32'h8000_0000, 32'h1);
        tests_run++;
        if (result !== 32'h7FFF_FFFF || ovf !== 1'b1 || zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_ovf: result=%h ovf=%b zero=%b, want 7fffffff 1 0", result, ovf, zero);
        end
        $display("[TB] SUB 80000000-1 -> %h ovf=%b", result, ovf);

        do_op(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        tests_run++;
        if (result !== 32'h0 || ovf !== 1'b0 || zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_wrap: result=%h ovf=%b zero=%b, want 00000000 0 1", result, ovf, zero);
        end
        $display("[TB] ADD ffffffff+1 -> %h ovf=%b", result, ovf);
    endtask

    task automatic test_shifts();
        do_op(OP_SRA, 32'h8000_0000, 32'h21);
        tests_run++;
        if (result !== 32'hC000_0000) begin
            tests_failed++;
            $display("FAIL sra: result=%h, want c0000000", result);
        end
        $display("[TB] SRA 80000000 by b=21 -> %h", result);

        do_op(OP_SRL, 32'h8000_0000, 32'h21);
        tests_run++;
        if (result !== 32'h4000_0000) begin
            tests_failed++;
            $display("FAIL srl: result=%h, want 40000000", result);
        end
        $display("[TB] SRL 80000000 by b=21 -> %h", result);

        do_op(OP_SLL, 32'h1, 32'd31);
        tests_run++;
        if (result !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL sll31: result=%h, want 80000000", result);
        end
        $display("[TB] SLL 1 by 31 -> %h", result);

        // b=32 leaves sh=0: upper bits of b are ignored.
        do_op(OP_SLL, 32'h1234, 32'd32);
        tests_run++;
        if (result !== 32'h1234 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL sll32: result=%h ovf=%b, want 00001234 0", result, ovf);
        end
        $display("[TB] SLL 1234 by b=32 -> %h", result);
    endtask

    task automatic test_logic_compare();
        do_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        tests_run++;
        if (result !== 32'hF000_F000) begin
            tests_failed++;
            $display("FAIL and: result=%h, want f000f000", result);
        end
        $display("[TB] AND -> %h", result);

        do_op(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        tests_run++;
        if (result !== 32'hFFF0_FFF0) begin
            tests_failed++;
            $display("FAIL or: result=%h, want fff0fff0", result);
        end
        $display("[TB] OR -> %h", result);

        do_op(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        tests_run++;
        if (result !== 32'h0FF0_0FF0) begin
            tests_failed++;
            $display("FAIL xor: result=%h, want 0ff00ff0", result);
        end
        $display("[TB] XOR -> %h", result);

        do_op(OP_SLT, 32'hFFFF_FFFF, 32'h1);
        tests_run++;
        if (result !== 32'h1 || zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL slt: result=%h zero=%b, want 00000001 0", result, zero);
        end
        $display("[TB] SLT ffffffff,1 -> %h", result);

        do_op(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
        tests_run++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL sltu: result=%h zero=%b, want 00000000 1", result, zero);
        end
        $display("[TB] SLTU ffffffff,1 -> %h", result);
    endtask

    task automatic test_mul_case(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic [WIDTH-1:0] exp);
        int bad;
        settle();
        op        = OP_MUL;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        // Keep a different op on the inputs while iterating; it must be ignored.
        op  = OP_ADD;
        a   = 32'h1;
        b   = 32'h1;
        bad = 0;
        for (int k = 0; k < WIDTH; k++) begin
            tests_run++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                tests_failed++;
                bad++;
                $display("FAIL mul_busy[%0d]: busy=%b in_ready=%b out_valid=%b, want 1 0 0",
                         k, busy, in_ready, out_valid);
            end
            if (k == WIDTH - 1) in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || result !== exp || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL mul_result: out_valid=%b busy=%b result=%h ovf=%b, want 1 0 %h 0",
                     out_valid, busy, result, ovf, exp);
        end
        $display("[TB] MUL %h*%h -> %h (busy-phase errors=%0d)", x, y, result, bad);
    endtask

    task automatic test_mul();
        test_mul_case(32'h0001_2345, 32'h0000_0100, 32'h0123_4500);
        test_mul_case(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    endtask

    task automatic test_backpressure();
        settle();
        op        = OP_ADD;
        a         = 32'd10;
        b         = 32'd20;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || result !== 32'd30 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold[%0d]: out_valid=%b result=%h in_ready=%b, want 1 0000001e 0",
                         k, out_valid, result, in_ready);
            end
            @(posedge clk);
            #1;
        end
        $display("[TB] back-pressure hold result=%h", result);

        op        = OP_ADD;
        a         = 32'd2;
        b         = 32'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_release_ready: in_ready=%b, want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'd5) begin
            tests_failed++;
            $display("FAIL hold_release_next: out_valid=%b result=%h, want 1 00000005", out_valid, result);
        end
        $display("[TB] release with new ADD 2+3 -> %h", result);
    endtask

    task automatic test_back_to_back();
        logic [3:0]       s_op  [4];
        logic [WIDTH-1:0] s_a   [4];
        logic [WIDTH-1:0] s_b   [4];
        logic [WIDTH-1:0] s_exp [4];
        s_op[0] = OP_ADD; s_a[0] = 32'd1;  s_b[0] = 32'd1;  s_exp[0] = 32'd2;
        s_op[1] = OP_SUB; s_a[1] = 32'd10; s_b[1] = 32'd3;  s_exp[1] = 32'd7;
        s_op[2] = OP_XOR; s_a[2] = 32'hFF; s_b[2] = 32'h0F; s_exp[2] = 32'hF0;
        s_op[3] = OP_SLL; s_a[3] = 32'd3;  s_b[3] = 32'd4;  s_exp[3] = 32'h30;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op       = s_op[i];
            a        = s_a[i];
            b        = s_b[i];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || result !== s_exp[i]) begin
                tests_failed++;
                $display("FAIL stream[%0d]: out_valid=%b result=%h, want 1 %h", i, out_valid, result, s_exp[i]);
            end
            $display("[TB] stream[%0d] op=%0d -> %h", i, s_op[i], result);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || result !== 32'h30) begin
            tests_failed++;
            $display("FAIL stream_drain: out_valid=%b result=%h, want 0 00000030", out_valid, result);
        end
        $display("[TB] stream drained, idle result=%h", result);
    endtask

    task automatic test_reset_mid_mul();
        do_op(OP_ADD, 32'd1, 32'd1);
        op       = OP_MUL;
        a        = 32'd3;
        b        = 32'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_mul_busy: busy=%b, want 1", busy);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1 ||
            zero !== 1'b0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_mul_reset: out_valid=%b busy=%b result=%h in_ready=%b zero=%b ovf=%b, want 0 0 00000000 1 0 0",
                     out_valid, busy, result, in_ready, zero, ovf);
        end
        repeat (WIDTH) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || result !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_mul_discard: out_valid=%b result=%h, want 0 00000000", out_valid, result);
        end
        $display("[TB] reset at MUL iteration 10 -> out_valid=%b busy=%b result=%h", out_valid, busy, result);
    endtask

    task automatic test_illegal();
        do_op(OP_ADD, 32'd7, 32'd8);
        do_op(4'd13, 32'd5, 32'd6);
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal13: out_valid=%b result=%h zero=%b ovf=%b, want 1 00000000 1 0",
                     out_valid, result, zero, ovf);
        end
        $display("[TB] illegal op 13 -> %h zero=%b", result, zero);
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shifts();
        test_logic_compare();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
